// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame states and the
// check-point offset used by the controller, sampler and deserializer.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_e;

    // The sampler's majority vote lands this many cycles past mid-bit, so
    // the voted bit is trusted (and the deserializer shifts) at (Prescale/2)+CP_OFFSET.
    localparam int CP_OFFSET = 3;

    // Oversample index at which a bit's voted value is consumed.
    function automatic int check_point(input int prescale);
        return (prescale >> 1) + CP_OFFSET;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit oversample counter (edge_cnt) and frame bit index (bit_cnt),
// with decoded end-of-bit (wrap) and check-point (cp) strobes.
module uart_rx_edge_bit_counter
    import uart_rx_pkg::*;
#(
    parameter int Prescale_Width = 6,
    parameter int Bit_Cnt_Width  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [Prescale_Width-1:0] prescale,
    output logic [Prescale_Width-1:0] edge_cnt,
    output logic [Bit_Cnt_Width-1:0]  bit_cnt,
    output logic                      wrap,
    output logic                      cp
);

    logic [Prescale_Width-1:0] last_edge;
    logic [Prescale_Width-1:0] cp_edge;

    assign last_edge = prescale - Prescale_Width'(1);
    assign cp_edge   = Prescale_Width'(check_point(int'(prescale)));
    assign wrap      = (edge_cnt == last_edge);
    assign cp        = (edge_cnt == cp_edge);

    // Count oversample edges; on the last edge of a bit wrap and advance the bit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable) begin
            if (wrap) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + Bit_Cnt_Width'(1);
            end else begin
                edge_cnt <= edge_cnt + Prescale_Width'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_controller.sv
// UART receive frame sequencer: tracks start/data/parity/stop bits, drives
// the sampler and deserializer enables, and flags frame errors.
module uart_rx_controller
    import uart_rx_pkg::*;
#(
    parameter int Data_Width     = 8,
    parameter int Prescale_Width = 6,
    parameter int Bit_Cnt_Width  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RX_IN,
    input  logic [Prescale_Width-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      Sampled_Bit,
    output logic [Prescale_Width-1:0] Edge_Cnt,
    output logic [Bit_Cnt_Width-1:0]  Bit_Cnt,
    output logic                      Dat_Samp_En,
    output logic                      Deser_En,
    output logic                      Data_Valid,
    output logic                      Par_Err,
    output logic                      Stp_Err,
    output logic                      Strt_Glitch
);

    localparam logic [Bit_Cnt_Width-1:0] LAST_DATA_BIT = Bit_Cnt_Width'(Data_Width);

    rx_state_e state;
    logic      par_acc;
    logic      cnt_en;
    logic      cnt_clr;
    logic      wrap;
    logic      cp;

    // Counters run only while a bit is being timed; IDLE and DONE hold them at zero,
    // and a rejected start or a sampled stop bit zeroes them for the next state.
    assign cnt_en  = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
    assign cnt_clr = (state == IDLE) || (state == DONE) ||
                     ((state == START) && cp && Sampled_Bit) ||
                     ((state == STOP) && cp);

    uart_rx_edge_bit_counter #(
        .Prescale_Width (Prescale_Width),
        .Bit_Cnt_Width  (Bit_Cnt_Width)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .enable   (cnt_en),
        .clear    (cnt_clr),
        .prescale (Prescale),
        .edge_cnt (Edge_Cnt),
        .bit_cnt  (Bit_Cnt),
        .wrap     (wrap),
        .cp       (cp)
    );

    // Enables and the valid pulse are pure decodes of registered state, so
    // nothing on RX_IN reaches them combinationally.
    assign Dat_Samp_En = cnt_en;
    assign Deser_En    = (state == DATA);
    assign Data_Valid  = (state == DONE) && !Par_Err && !Stp_Err;

    // Frame FSM with parity accumulation and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            par_acc     <= 1'b0;
            Par_Err     <= 1'b0;
            Stp_Err     <= 1'b0;
            Strt_Glitch <= 1'b0;
        end else begin
            Strt_Glitch <= 1'b0;
            case (state)
                IDLE: begin
                    // Flags from the previous frame stay visible until a new start arrives.
                    if (!RX_IN) begin
                        state   <= START;
                        par_acc <= 1'b0;
                        Par_Err <= 1'b0;
                        Stp_Err <= 1'b0;
                    end
                end
                START: begin
                    // A start bit that reads high at the check point was noise.
                    if (cp && Sampled_Bit) begin
                        Strt_Glitch <= 1'b1;
                        state       <= IDLE;
                    end else if (wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (cp) begin
                        par_acc <= par_acc ^ Sampled_Bit;
                    end
                    if (wrap && (Bit_Cnt == LAST_DATA_BIT)) begin
                        state <= PAR_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (cp) begin
                        Par_Err <= (Sampled_Bit != (par_acc ^ PAR_TYP));
                    end
                    if (wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Leave mid stop bit so a back-to-back start edge is seen in IDLE.
                    if (cp) begin
                        Stp_Err <= ~Sampled_Bit;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller with a behavioural 3-sample majority
// sampler and an LSB-first deserializer around the DUT.
module tb_uart_rx_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit = 1'b1;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       deser_en;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       strt_glitch;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_controller dut (
        .clk         (clk),
        .rst         (rst),
        .RX_IN       (rx_in),
        .Prescale    (prescale),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .Sampled_Bit (sampled_bit),
        .Edge_Cnt    (edge_cnt),
        .Bit_Cnt     (bit_cnt),
        .Dat_Samp_En (dat_samp_en),
        .Deser_En    (deser_en),
        .Data_Valid  (data_valid),
        .Par_Err     (par_err),
        .Stp_Err     (stp_err),
        .Strt_Glitch (strt_glitch)
    );

    // Sampler: vote over oversamples half-1, half, half+1 of each bit.
    logic [5:0] half;
    logic       s0 = 1'b1;
    logic       s1 = 1'b1;
    assign half = prescale >> 1;

    always @(posedge clk) begin
        if (dat_samp_en) begin
            if (edge_cnt == half - 6'd1) s0 <= rx_in;
            if (edge_cnt == half)        s1 <= rx_in;
            if (edge_cnt == half + 6'd1) sampled_bit <= (s0 & s1) | (s0 & rx_in) | (s1 & rx_in);
        end
    end

    // Deserializer: shift in at the check point (half+3), LSB first.
    logic [7:0] p_data = 8'h00;
    always @(posedge clk) begin
        if (deser_en && edge_cnt == half + 6'd3) p_data <= {sampled_bit, p_data[7:1]};
    end

    // Monitor on the falling edge: pulse counters and captured values.
    int         dv_cnt   = 0;
    int         sg_cnt   = 0;
    int         de_cnt   = 0;
    int         both_cnt = 0;
    logic [7:0] dv_data  = 8'h00;
    logic [5:0] prev_edge = 6'd0;
    logic [5:0] sg_edge   = 6'd0;

    always @(negedge clk) begin
        if (data_valid === 1'b1) begin
            dv_cnt  <= dv_cnt + 1;
            dv_data <= p_data;
        end
        if (strt_glitch === 1'b1) begin
            sg_cnt  <= sg_cnt + 1;
            sg_edge <= prev_edge;
        end
        if (deser_en === 1'b1) de_cnt <= de_cnt + 1;
        if (data_valid === 1'b1 && strt_glitch === 1'b1) both_cnt <= both_cnt + 1;
        prev_edge <= edge_cnt;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) @(negedge clk);
    endtask

    // One frame, line driven on falling edges. A bad stop bit is held low only
    // past its sample point so the trailing low is not taken as a new start.
    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input logic par_bit, input logic stop_bit);
        int p;
        p = int'(prescale);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (with_par) send_bit(par_bit, p);
        if (stop_bit) begin
            send_bit(1'b1, p);
        end else begin
            send_bit(1'b0, (p >> 1) + 4);
            send_bit(1'b1, p - (p >> 1) - 4);
        end
    endtask

    int dv0, sg0, de0;

    initial begin
        rst      = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b1;
        par_typ  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        check("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        check("rst_samp_en", 32'(dat_samp_en), 32'd0);
        check("rst_deser_en", 32'(deser_en), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        check("rst_stp_err", 32'(stp_err), 32'd0);
        check("rst_strt_glitch", 32'(strt_glitch), 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Prescale 8, even parity, 0xA5 (four ones -> parity bit 0)
        dv0 = dv_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_dv_pulses", 32'(dv_cnt - dv0), 32'd1);
        check("a5_data", 32'(dv_data), 32'hA5);
        check("a5_par_err", 32'(par_err), 32'd0);
        check("a5_stp_err", 32'(stp_err), 32'd0);
        check("a5_idle_samp_en", 32'(dat_samp_en), 32'd0);

        // Same frame under odd parity -> parity error, no valid, flag sticks
        par_typ = 1'b1;
        dv0 = dv_cnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("odd_par_err", 32'(par_err), 32'd1);
        check("odd_no_dv", 32'(dv_cnt - dv0), 32'd0);
        repeat (30) @(negedge clk);
        check("odd_par_err_held", 32'(par_err), 32'd1);

        // Prescale 16, no parity, 0x3C with a low stop bit
        prescale = 6'd16;
        par_en   = 1'b0;
        dv0 = dv_cnt;
        de0 = de_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("stp_stp_err", 32'(stp_err), 32'd1);
        check("stp_no_dv", 32'(dv_cnt - dv0), 32'd0);
        check("stp_deser_cycles", 32'(de_cnt - de0), 32'd128);
        check("stp_par_err_cleared", 32'(par_err), 32'd0);
        check("stp_data", 32'(p_data), 32'h3C);

        // Prescale 8, start held low for only 3 cycles
        prescale = 6'd8;
        sg0 = sg_cnt;
        de0 = de_cnt;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_pulses", 32'(sg_cnt - sg0), 32'd1);
        check("glitch_at_edge", 32'(sg_edge), 32'd7);
        check("glitch_no_deser", 32'(de_cnt - de0), 32'd0);
        check("glitch_idle_edge", 32'(edge_cnt), 32'd0);
        check("glitch_idle_samp", 32'(dat_samp_en), 32'd0);
        check("glitch_stp_cleared", 32'(stp_err), 32'd0);

        // Prescale 32, back-to-back 0x55 then 0xAA
        prescale = 6'd32;
        dv0 = dv_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        check("b2b_first_dv", 32'(dv_cnt - dv0), 32'd1);
        check("b2b_first_data", 32'(dv_data), 32'h55);
        send_frame(8'hAA, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_total_dv", 32'(dv_cnt - dv0), 32'd2);
        check("b2b_second_data", 32'(dv_data), 32'hAA);

        // Reset in the middle of data bit index 4 at Prescale 8
        prescale = 6'd8;
        dv0 = dv_cnt;
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_bit(1'b1, 4);
        check("mid_bit_cnt", 32'(bit_cnt), 32'd4);
        check("mid_deser_en", 32'(deser_en), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_edge_cnt", 32'(edge_cnt), 32'd0);
        check("abort_bit_cnt", 32'(bit_cnt), 32'd0);
        check("abort_deser_en", 32'(deser_en), 32'd0);
        check("abort_samp_en", 32'(dat_samp_en), 32'd0);
        rx_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_dv", 32'(dv_cnt - dv0), 32'd0);

        // Clean 0x81 after the abort: Prescale 16, odd parity (two ones -> bit 1)
        prescale = 6'd16;
        par_en   = 1'b1;
        par_typ  = 1'b1;
        dv0 = dv_cnt;
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("post_rst_dv", 32'(dv_cnt - dv0), 32'd1);
        check("post_rst_data", 32'(dv_data), 32'h81);
        check("post_rst_par_err", 32'(par_err), 32'd0);
        check("dv_glitch_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
Frame-level sequencer for the UART receive path. It watches the serial line, runs the per-bit edge/bit counters, and enables the data sampler and the deserializer at the right cycles. It checks start, parity and stop bits, and raises a one-cycle Data_Valid when a clean byte is ready in the deserializer. It sits between RX_IN and the sampler/deserializer pair, in the same oversampled clock domain.

Parameters:
Data_Width, 8, data bits per frame; must equal the deserializer's Data_Width.
Prescale_Width, 6, width of Prescale and Edge_Cnt.
Bit_Cnt_Width, 4, width of Bit_Cnt; must hold Data_Width+2.

Ports:
clk  in  1  oversampling clock
rst  in  1  asynchronous active-low reset
RX_IN  in  1  serial line, idle high
Prescale  in  Prescale_Width  oversampling ratio; legal values 8/16/32; static while a frame is in progress
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even, 1 = odd
Sampled_Bit  in  1  majority-voted bit from sampler, valid at check point
Edge_Cnt  out  Prescale_Width  oversample index within current bit, 0..Prescale-1
Bit_Cnt  out  Bit_Cnt_Width  bit index in frame (0 = start)
Dat_Samp_En  out  1  sampler enable
Deser_En  out  1  deserializer shift enable
Data_Valid  out  1  one-cycle pulse: byte good
Par_Err  out  1  parity error flag for last frame
Stp_Err  out  1  stop error flag for last frame
Strt_Glitch  out  1  one-cycle pulse: false start rejected

Behaviour:
- Reset: state IDLE, all outputs 0, internal parity accumulator 0.
- Check point CP = (Prescale>>1)+3. This is the same cycle on which the deserializer captures.
- Edge_Cnt is 0 in IDLE and DONE. Elsewhere it increments every clk. At Prescale-1 it wraps to 0 and Bit_Cnt increments.
- IDLE: if RX_IN==0, go to START next cycle with Edge_Cnt=0 and Bit_Cnt=0.
- START:
  - Clear Par_Err, Stp_Err and the parity accumulator on entry.
  - At CP, if Sampled_Bit==1: pulse Strt_Glitch, go to IDLE, clear the counters.
  - Otherwise, at Edge_Cnt==Prescale-1, go to DATA.
- DATA:
  - Deser_En=1 throughout the state.
  - At CP, parity accumulator ^= Sampled_Bit.
  - At Edge_Cnt==Prescale-1 with Bit_Cnt==Data_Width, go to PARITY if PAR_EN, else STOP.
- PARITY:
  - At CP, expected = accumulator ^ PAR_TYP; Par_Err <= (Sampled_Bit != expected).
  - At wrap, go to STOP.
- STOP: at CP, Stp_Err <= ~Sampled_Bit, then go to DONE next cycle.
- DONE: lasts one cycle.
  - Data_Valid = ~Par_Err & ~Stp_Err.
  - Next state is IDLE, with counters cleared.
  - DONE precedes the stop bit's end, so a back-to-back start edge is caught in IDLE.
- Dat_Samp_En=1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- Par_Err and Stp_Err hold until the next frame's START entry.
- Data_Valid and Strt_Glitch are never asserted in the same cycle.
- PAR_EN and PAR_TYP are sampled only at their use points, so changes mid-frame take effect at the next use.
- Asynchronous reset mid-frame aborts the frame: no Data_Valid, flags cleared.
- Outputs are registered or decoded from state. No combinational path from RX_IN to Deser_En.

Decomposition:
- Package uart_rx_pkg: state encoding (IDLE, START, DATA, PARITY, STOP, DONE) and the CP offset constant 3, shared with the deserializer and the sampler.
- One sub-module: uart_rx_edge_bit_counter. It holds Edge_Cnt/Bit_Cnt, with inputs enable, clear and Prescale, and outputs the wrap and CP strobes.
- FSM and error logic live in the top.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 → Data_Valid for one cycle, P_Data=0xA5, Par_Err=0, Stp_Err=0.
- Same frame with PAR_TYP=1 → Par_Err=1, no Data_Valid; flag holds until the next start.
- Prescale=16, PAR_EN=0, byte 0x3C, stop bit driven 0 → Stp_Err=1, no Data_Valid, Deser_En high for exactly 8×16 cycles.
- Prescale=8, RX_IN low for 3 cycles then high → Strt_Glitch pulse at Edge_Cnt=7, back to IDLE, Deser_En never asserted.
- Two back-to-back frames 0x55 then 0xAA at Prescale=32, PAR_EN=0 → two Data_Valid pulses, the second start not missed.
- Reset asserted mid-DATA at Bit_Cnt=4 → all outputs 0 immediately; the next clean frame 0x81 is received correctly.
